// File: rtl/button_event_if.sv
// Button event bus: raw pin levels in, debounced levels and one-cycle events out.
// The master drives the raw button levels; the slave (the decoder) drives the events.
interface button_event_if #(
    parameter int N_BTN = 8
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic             short_pulse;
    logic             long_pulse;
    logic             hold_active;

    modport master (
        output btn_raw,
        input  btn_level, press_pulse, release_pulse,
        input  short_pulse, long_pulse, hold_active
    );

    modport slave (
        input  btn_raw,
        output btn_level, press_pulse, release_pulse,
        output short_pulse, long_pulse, hold_active
    );
endinterface

// File: rtl/button_event_decoder.sv
// Front-panel button conditioning: 2-flop synchroniser and debounce per button,
// registered press/release pulses, and short/long classification of the power
// button (LONG_IDX). Optional feature macro BTN_AUTO_REPEAT_EN adds auto-repeat
// press pulses on every other held button.
//
// Power-button FSM:
//   state    | meaning
//   ST_IDLE  | power button released (debounced)
//   ST_HELD  | pressed, long threshold not yet reached
//   ST_LONG  | long press reported, waiting for release
module button_event_decoder #(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 300_000_000,
    parameter int LONG_IDX        = 2,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input logic           clk,
    input logic           rst,
    button_event_if.slave btn
);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    // Comparing the pre-update count lets long_pulse be registered on the
    // same edge the count becomes LONG_CYCLES-1.
    localparam logic [HOLD_W-1:0] LONG_ARM = HOLD_W'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } pwr_state_t;

    logic [N_BTN-1:0] sync_1;
    logic [N_BTN-1:0] sync_2;
    logic [N_BTN-1:0] stable;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] flip;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] rep_fire;

    logic [HOLD_W-1:0] hold_cnt;
    pwr_state_t        state;
    pwr_state_t        state_nxt;
    logic              short_nxt;
    logic              long_nxt;

    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic             short_q;
    logic             long_q;
    logic             hold_q;

    // A button flips once its synchronised level has differed for the full debounce window.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            flip[i] = (sync_2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    assign rise = flip & ~stable;
    assign fall = flip & stable;

    // Synchroniser, debounce counters and the accepted (stable) levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
            stable <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_1 <= btn.btn_raw;
            sync_2 <= sync_1;
            stable <= stable ^ flip;
            for (int i = 0; i < N_BTN; i++) begin
                if ((sync_2[i] == stable[i]) || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Power-button hold counter: idle at zero while released, saturates at the long threshold.
    always_ff @(posedge clk) begin
        if (rst || !stable[LONG_IDX]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_SPAN = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int REP_W    = $clog2(REP_SPAN) + 1;
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(LONG_CYCLES - 2);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt [N_BTN];
    logic [N_BTN-1:0] rep_phase;

    // Repeat fires first after the long delay, then every REPEAT_CYCLES; never on a releasing edge.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (i != LONG_IDX && stable[i] && !fall[i]) begin
                rep_fire[i] = (rep_cnt[i] == (rep_phase[i] ? REP_NEXT : REP_FIRST));
            end
        end
    end

    // Per-button repeat counters; the power button keeps its own classification instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst || !stable[i] || i == LONG_IDX) begin
                rep_cnt[i]   <= '0;
                rep_phase[i] <= 1'b0;
            end else if (rep_fire[i]) begin
                rep_cnt[i]   <= '0;
                rep_phase[i] <= 1'b1;
            end else begin
                rep_cnt[i]   <= rep_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Power-button FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Power-button classification; a release on the threshold edge still counts as short.
    always_comb begin
        state_nxt = state;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise[LONG_IDX]) begin
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall[LONG_IDX]) begin
                    state_nxt = ST_IDLE;
                    short_nxt = 1'b1;
                end else if (hold_cnt == LONG_ARM) begin
                    state_nxt = ST_LONG;
                    long_nxt  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall[LONG_IDX]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_q   <= '0;
            release_q <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            press_q   <= rise | rep_fire;
            release_q <= fall;
            short_q   <= short_nxt;
            long_q    <= long_nxt;
            hold_q    <= (state_nxt == ST_LONG);
        end
    end

    assign btn.btn_level     = stable;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.short_pulse   = short_q;
    assign btn.long_pulse    = long_q;
    assign btn.hold_active   = hold_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios with literal latencies,
// then random chatter/holds/resets, all checked every cycle against an
// event-level model (raw-sample window acceptance, press age in cycles).
module tb_button_event_decoder;
    localparam int N    = 8;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam int LIDX = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    button_event_if #(.N_BTN(N)) bus ();
    assign bus.btn_raw = raw;

    button_event_decoder #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG),
        .LONG_IDX(LIDX),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(bus)
    );

    // ---------------- behavioural model ----------------
    // A level is accepted once the last DEB raw samples, seen through the
    // two-cycle synchroniser delay, all disagree with the current level.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_level, m_press, m_release;
    logic         m_short, m_long, m_hold;
    int           age [N];
    bit           model_on = 0;

    always @(posedge clk) begin
        bit all_other;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
            m_level = '0; m_press = '0; m_release = '0;
            m_short = 0; m_long = 0; m_hold = 0;
            for (int i = 0; i < N; i++) age[i] = 0;
            model_on = 1;
        end else if (model_on) begin
            hist.push_back(raw);
            void'(hist.pop_front());
            m_press = '0; m_release = '0; m_short = 0; m_long = 0;
            for (int i = 0; i < N; i++) begin
                all_other = 1;
                for (int k = 0; k < DEB; k++)
                    if (hist[k][i] == m_level[i]) all_other = 0;
                if (all_other) begin
                    if (!m_level[i]) begin
                        m_press[i] = 1;
                        age[i] = 1;
                    end else begin
                        m_release[i] = 1;
                        age[i] = 0;
                        if (i == LIDX) begin
                            if (!m_hold) m_short = 1;
                            m_hold = 0;
                        end
                    end
                    m_level[i] = ~m_level[i];
                end else if (m_level[i]) begin
                    age[i]++;
                    if (i == LIDX && age[i] == LONG) begin
                        m_long = 1;
                        m_hold = 1;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    if (i != LIDX && age[i] >= LONG && ((age[i] - LONG) % REP) == 0)
                        m_press[i] = 1;
`endif
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            compared++;
            if ({bus.btn_level, bus.press_pulse, bus.release_pulse,
                 bus.short_pulse, bus.long_pulse, bus.hold_active} !==
                {m_level, m_press, m_release, m_short, m_long, m_hold}) begin
                mismatched++;
                $display("FAIL cycle_compare t=%0t got lvl=%b prs=%b rel=%b s=%b l=%b h=%b want lvl=%b prs=%b rel=%b s=%b l=%b h=%b",
                         $time, bus.btn_level, bus.press_pulse, bus.release_pulse,
                         bus.short_pulse, bus.long_pulse, bus.hold_active,
                         m_level, m_press, m_release, m_short, m_long, m_hold);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit sig(input int kind, input int b);
        case (kind)
            0: return bus.press_pulse[b];
            1: return bus.release_pulse[b];
            2: return bus.long_pulse;
            3: return bus.short_pulse;
            default: return 1'b0;
        endcase
    endfunction

    // Counts negedges until the selected event is seen; -1 if the budget expires.
    task automatic wait_for(input int kind, input int b, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(kind, b) && n < limit);
        if (!sig(kind, b)) n = -1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, longs, rel;
        int offs [$];
        int rate;

        raw = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_level", int'(bus.btn_level), 0);
        chk("reset_hold", int'(bus.hold_active), 0);
        rst = 1'b0;

        // Clean press on button 0, held 30 clk.
        raw[0] = 1'b1;
        wait_for(0, 0, 20, n);
        chk("press_latency", n, DEB + 2);
        chk("press_level", int'(bus.btn_level[0]), 1);
        @(negedge clk);
        chk("press_single_cycle", int'(bus.press_pulse[0]), 0);
        repeat (30 - n - 1) @(negedge clk);
        raw[0] = 1'b0;
        wait_for(1, 0, 20, n);
        chk("release_latency", n, DEB + 2);
        chk("release_level", int'(bus.btn_level[0]), 0);
        repeat (5) @(negedge clk);

        // Glitch on button 4 shorter than the debounce window.
        raw[4] = 1'b1;
        repeat (3) @(negedge clk);
        raw[4] = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.press_pulse[4] || bus.release_pulse[4] || bus.btn_level[4]) cnt++;
        end
        chk("glitch_events", cnt, 0);

        // Short power press.
        raw[LIDX] = 1'b1;
        longs = 0;
        repeat (10) begin
            @(negedge clk);
            longs += int'(bus.long_pulse);
        end
        raw[LIDX] = 1'b0;
        wait_for(3, 0, 20, n);
        chk("short_seen", int'(n > 0), 1);
        chk("short_with_release", int'(bus.release_pulse[LIDX]), 1);
        chk("short_no_long", longs, 0);
        repeat (5) @(negedge clk);

        // Long power press: press cycle counts as the first of LONG cycles.
        raw[LIDX] = 1'b1;
        wait_for(0, LIDX, 20, n);
        chk("long_press_latency", n, DEB + 2);
        wait_for(2, 0, 40, n);
        chk("long_after_press", n, LONG - 1);
        chk("long_hold_active", int'(bus.hold_active), 1);
        longs = 0;
        repeat (15) begin
            @(negedge clk);
            longs += int'(bus.long_pulse);
        end
        chk("long_fires_once", longs, 0);
        raw[LIDX] = 1'b0;
        wait_for(1, LIDX, 20, n);
        chk("long_release_seen", int'(n > 0), 1);
        chk("long_release_no_short", int'(bus.short_pulse), 0);
        chk("long_release_hold_clear", int'(bus.hold_active), 0);
        repeat (5) @(negedge clk);

        // Reset in the middle of a power-button hold.
        raw[LIDX] = 1'b1;
        wait_for(0, LIDX, 20, n);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midhold_reset_level", int'(bus.btn_level), 0);
        chk("midhold_reset_press", int'(bus.press_pulse), 0);
        rst = 1'b0;
        wait_for(0, LIDX, 20, n);
        chk("repress_after_reset", n, DEB + 2);
        repeat (4) @(negedge clk);
        raw[LIDX] = 1'b0;
        wait_for(1, LIDX, 20, n);
        chk("repress_release_short", int'(bus.short_pulse), 1);
        repeat (5) @(negedge clk);

        // Auto-repeat on button 0 held 50 clk.
        raw[0] = 1'b1;
        wait_for(0, 0, 20, n);
        offs.delete();
        offs.push_back(1);
        for (rel = 2; rel <= 45; rel++) begin
            @(negedge clk);
            if (bus.press_pulse[0]) offs.push_back(rel);
        end
        raw[0] = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        chk("repeat_count", offs.size(), 5);
        if (offs.size() == 5) begin
            chk("repeat_1", offs[1], 20);
            chk("repeat_2", offs[2], 28);
            chk("repeat_3", offs[3], 36);
            chk("repeat_4", offs[4], 44);
        end
`else
        chk("no_repeat_count", offs.size(), 1);
`endif
        repeat (10) @(negedge clk);

        // Randomised chatter, holds and occasional resets.
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: rate = 3;
                1: rate = 12;
                2: rate = 40;
                default: rate = 8;
            endcase
            repeat (800) begin
                @(negedge clk);
                rst = ($urandom_range(0, 499) == 0);
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, rate - 1) == 0) raw[b] = ~raw[b];
            end
        end
        rst = 1'b0;
        raw = '0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Input-side conditioning for the range-hood controller: turns raw front-panel buttons into clean, single-cycle events. This is the input counterpart to the 7-segment display path. It sits between the board pins and the control FSMs (on/off control, mode and menu selection, left/right gestures). It synchronises and debounces every button, emits press and release pulses, and classifies the designated power button as a short press or a long hold (≥3 s at 100 MHz).

## Interface
Parameters:
- N_BTN, 8: number of buttons; bit order = left, right, on_off, menu, mode1, mode2, mode3, self_clean (index 0 = left).
- DEBOUNCE_CYCLES, 2_000_000: clocks a synchronised level must hold before it is accepted (20 ms at 100 MHz).
- LONG_CYCLES, 300_000_000: hold length that qualifies as a long press (3 s).
- LONG_IDX, 2: button index with short/long classification (on_off).
- REPEAT_CYCLES, 25_000_000: auto-repeat period; used only with BTN_AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button levels, 1 = pressed.
- btn_level  out  N_BTN  debounced level per button.
- press_pulse  out  N_BTN  one-cycle pulse per accepted press (plus repeats, see Configuration).
- release_pulse  out  N_BTN  one-cycle pulse per accepted release.
- short_pulse  out  1  one-cycle pulse on release of LONG_IDX when the long threshold was not reached.
- long_pulse  out  1  one-cycle pulse when LONG_IDX has been held LONG_CYCLES clocks.
- hold_active  out  1  high from long_pulse until LONG_IDX debounced release.

## Operation
- Per button: 2-flop synchroniser, then debounce counter of width $clog2(DEBOUNCE_CYCLES).
  - Counter clears whenever the synchronised level equals the stable level.
  - Counter increments while the two differ.
  - At count DEBOUNCE_CYCLES-1 (still differing), the stable level flips and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES clocks is never accepted and produces no pulse.
- When stable rises:
  - btn_level[i] rises.
  - press_pulse[i] is 1 in that same registered cycle.
- When stable falls: release_pulse[i] is 1 in the cycle btn_level[i] falls.
- LONG_IDX hold counter:
  - Width $clog2(LONG_CYCLES)+1; clears while btn_level[LONG_IDX]=0.
  - Counts while the button is held and saturates at LONG_CYCLES.
  - long_pulse fires once, on the clock the count reaches LONG_CYCLES-1; no repeat within the same press.
  - hold_active sets together with long_pulse.
- LONG_IDX release:
  - If long did not fire, short_pulse and release_pulse assert together.
  - If long fired, only release_pulse asserts, and hold_active clears in the same cycle.
- Buttons are fully independent; simultaneous presses on several bits give simultaneous pulses.
- No press priority or masking happens here; that belongs to the consumer FSMs.

## Timing
- Reset (rst=1 at a clk edge) clears:
  - all synchroniser, stable, counter and output registers;
  - every output, including btn_level = 0 and all pulses = 0.
- Press latency: 2 (sync) + DEBOUNCE_CYCLES clocks from the raw edge to press_pulse. Release latency is identical.
- long_pulse arrives LONG_CYCLES clocks after press_pulse[LONG_IDX], counting the press cycle as 1.
- Button held through reset: after rst falls it is treated as a fresh press, with press_pulse after 2+DEBOUNCE_CYCLES clocks.
- Reset mid-hold aborts the pending long press; no short_pulse or release_pulse is emitted for that press.
- All pulses are exactly one clk cycle wide and registered; no outputs are combinational.

## Configuration
- BTN_AUTO_REPEAT_EN defined:
  - For every button i ≠ LONG_IDX held continuously, an extra press_pulse[i] fires at LONG_CYCLES clocks after the initial press.
  - Further pulses follow every REPEAT_CYCLES clocks until release.
  - Each button gets its own hold counter.
- BTN_AUTO_REPEAT_EN undefined:
  - Exactly one press_pulse per accepted press.
  - No per-button hold counters are built; only LONG_IDX has one.
  - REPEAT_CYCLES is ignored.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: btn_raw[0] 0→1, held 30 clk.
  - press_pulse[0] single cycle 6 clk after the raw edge; btn_level[0]=1.
  - Release gives release_pulse[0] 6 clk later.
- Glitch: btn_raw[4] high for 3 clk, then low → no press_pulse, no release_pulse, btn_level stays 0.
- Short power press: btn_raw[2] held 10 clk → short_pulse and release_pulse[2] in the same cycle; long_pulse never asserts.
- Long power press: btn_raw[2] held 40 clk.
  - long_pulse fires once, 20 clk after press_pulse[2]; hold_active=1.
  - On release: release_pulse[2] only, no short_pulse, hold_active→0.
- Reset mid-hold: btn_raw[2] held; rst pulsed at clk 12 after press_pulse.
  - All outputs go to 0 the next edge; no long_pulse.
  - New press_pulse[2] 6 clk after rst falls.
- With BTN_AUTO_REPEAT_EN, btn_raw[0] held 50 clk → press_pulse[0] at relative clk 1, 20, 28, 36, 44.
